// File: rtl/mux64_sched_defs_pkg.sv
// Shared definitions for the 64-requester round-robin mux scheduler.
// Optional build macro SCHED_LOCK_EN is consumed by mux64_rr_sched.
package mux64_sched_defs;

  localparam int N  = 64;
  localparam int SW = 6;
  localparam int DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  function automatic logic [N-1:0] onehot(input logic [SW-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick64.sv
// Rotating-priority encoder: first set req bit scanning ptr+1, ptr+2, ... mod 64.
// Pure combinational; ptr itself is examined last.
module rr_pick64
  import mux64_sched_defs::*;
(
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] win,
  output logic          any
);

  logic [SW-1:0] idx;

  always_comb begin
    win = '0;
    any = 1'b0;
    idx = '0;
    // SW'(i) truncation makes the i=N step land back on ptr itself.
    for (int i = 1; i <= N; i++) begin
      idx = ptr + SW'(i);
      if (!any && req[idx]) begin
        win = idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux64_rr_sched.sv
// Round-robin scheduler driving the mux_16_64w select, capturing its word and
// presenting it on valid/ready. Define SCHED_LOCK_EN for the burst-lock port.
module mux64_rr_sched
  import mux64_sched_defs::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [SW-1:0] sel,
  input  logic [DW-1:0] din,
  output logic [N-1:0]  gnt,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready
`ifdef SCHED_LOCK_EN
  ,
  input  logic          lock
`endif
);

  state_e        state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          dout_valid_q, dout_valid_d;

  logic [SW-1:0] pick_win;
  logic          pick_any;
  logic          relock;
  logic          go;
  logic [SW-1:0] win;
  logic          hs;

  rr_pick64 u_pick (
    .req (req),
    .ptr (ptr_q),
    .win (pick_win),
    .any (pick_any)
  );

`ifdef SCHED_LOCK_EN
  logic lock_hold_q, lock_hold_d;
  // A locked requester that is still asking is re-served before any scan.
  assign relock = lock_hold_q & req[sel_q];
`else
  assign relock = 1'b0;
`endif

  always_comb begin
    go  = pick_any;
    win = pick_win;
    if (relock) begin
      go  = 1'b1;
      win = sel_q;
    end
  end

  assign hs = (state_q == ST_HOLD) && dout_valid_q && dout_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      ptr_q        <= SW'(N - 1);
      gnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
`ifdef SCHED_LOCK_EN
      lock_hold_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      ptr_q        <= ptr_d;
      gnt_q        <= gnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
`ifdef SCHED_LOCK_EN
      lock_hold_q  <= lock_hold_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (go) state_d = ST_SAMPLE;
      ST_SAMPLE: state_d = ST_HOLD;
      ST_HOLD:   if (hs) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sel_d        = sel_q;
    ptr_d        = ptr_q;
    gnt_d        = '0;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
`ifdef SCHED_LOCK_EN
    lock_hold_d  = lock_hold_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          sel_d = win;
`ifdef SCHED_LOCK_EN
          lock_hold_d = 1'b0;
`endif
        end
      end
      // sel has been stable a full cycle, so din is settled at this edge.
      ST_SAMPLE: begin
        dout_d       = din;
        dout_valid_d = 1'b1;
        gnt_d        = onehot(sel_q);
      end
      ST_HOLD: begin
        if (hs) begin
          dout_valid_d = 1'b0;
`ifdef SCHED_LOCK_EN
          if (lock && req[sel_q]) begin
            lock_hold_d = 1'b1;
          end else begin
            ptr_d = sel_q;
          end
`else
          ptr_d = sel_q;
`endif
        end
      end
      default: ;
    endcase
  end

  assign sel        = sel_q;
  assign gnt        = gnt_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_mux64_rr_sched.sv
// Directed, table-driven bench for mux64_rr_sched with a behavioural mux on din.
module tb_mux64_rr_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] req;
  logic [5:0]  sel;
  logic [15:0] din;
  logic [63:0] gnt;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready;
`ifdef SCHED_LOCK_EN
  logic        lock;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [63:0] req;
    logic [5:0]  win;
  } vec_t;

  vec_t vecs [14];

  always #5 clk = ~clk;

  function automatic logic [15:0] din_of(input logic [5:0] s);
    if (s == 6'd5) return 16'hA5A5;
    return {4'h3, s, ~s};
  endfunction

  function automatic logic [63:0] bit_of(input int k);
    logic [63:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  assign din = din_of(sel);

  mux64_rr_sched dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .sel        (sel),
    .din        (din),
    .gnt        (gnt),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
`ifdef SCHED_LOCK_EN
    ,
    .lock       (lock)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut;
    req = '0;
    dout_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One full transaction from IDLE with ready held high: select, capture, handshake.
  task automatic xact(input logic [63:0] r, input logic [5:0] w, input string tag);
    req = r;
    dout_ready = 1'b1;
    tick;
    chk({tag, " sel"}, 64'(sel), 64'(w));
    chk({tag, " valid_pre"}, 64'(dout_valid), 64'(0));
    chk({tag, " gnt_pre"}, gnt, 64'(0));
    tick;
    chk({tag, " gnt"}, gnt, bit_of(int'(w)));
    chk({tag, " dout"}, 64'(dout), 64'(din_of(w)));
    chk({tag, " valid"}, 64'(dout_valid), 64'(1));
    tick;
    chk({tag, " valid_post"}, 64'(dout_valid), 64'(0));
    chk({tag, " gnt_post"}, gnt, 64'(0));
  endtask

  initial begin
    vecs[0]  = '{bit_of(0) | bit_of(63), 6'd0};
    vecs[1]  = '{bit_of(0) | bit_of(63), 6'd63};
    vecs[2]  = '{bit_of(0) | bit_of(63), 6'd0};
    vecs[3]  = '{bit_of(0) | bit_of(63), 6'd63};
    vecs[4]  = '{bit_of(62), 6'd62};
    vecs[5]  = '{bit_of(1) | bit_of(62), 6'd1};
    vecs[6]  = '{bit_of(1) | bit_of(62), 6'd62};
    vecs[7]  = '{{64{1'b1}}, 6'd63};
    vecs[8]  = '{{64{1'b1}}, 6'd0};
    vecs[9]  = '{bit_of(0), 6'd0};
    vecs[10] = '{bit_of(10) | bit_of(20) | bit_of(30), 6'd10};
    vecs[11] = '{bit_of(10) | bit_of(20) | bit_of(30), 6'd20};
    vecs[12] = '{bit_of(10) | bit_of(20) | bit_of(30), 6'd30};
    vecs[13] = '{bit_of(10) | bit_of(20) | bit_of(30), 6'd10};

`ifdef SCHED_LOCK_EN
    lock = 1'b0;
`endif
    reset_dut;

    for (int c = 0; c < 20; c++) begin
      chk("rst sel", 64'(sel), 64'(0));
      chk("rst gnt", gnt, 64'(0));
      chk("rst valid", 64'(dout_valid), 64'(0));
      chk("rst dout", 64'(dout), 64'(0));
      tick;
    end

    xact(bit_of(5), 6'd5, "first_req5");
    chk("req5 gnt_value", gnt, 64'h0);

    reset_dut;
    for (int v = 0; v < 14; v++) begin
      xact(vecs[v].req, vecs[v].win, $sformatf("vec%0d", v));
    end

    // Request withdrawn in SAMPLE is still served.
    req = bit_of(3);
    dout_ready = 1'b1;
    tick;
    chk("drop sel", 64'(sel), 64'(3));
    req = '0;
    tick;
    chk("drop gnt", gnt, bit_of(3));
    chk("drop valid", 64'(dout_valid), 64'(1));
    chk("drop dout", 64'(dout), 64'(din_of(6'd3)));
    tick;
    chk("drop valid_post", 64'(dout_valid), 64'(0));
    tick;
    chk("idle stays", 64'(dout_valid), 64'(0));

    // Back-pressure in HOLD.
    req = bit_of(40);
    dout_ready = 1'b0;
    tick;
    chk("bp sel0", 64'(sel), 64'(40));
    tick;
    chk("bp gnt0", gnt, bit_of(40));
    req = '0;
    for (int c = 0; c < 5; c++) begin
      tick;
      chk($sformatf("bp valid c%0d", c), 64'(dout_valid), 64'(1));
      chk($sformatf("bp sel c%0d", c), 64'(sel), 64'(40));
      chk($sformatf("bp dout c%0d", c), 64'(dout), 64'(din_of(6'd40)));
      chk($sformatf("bp gnt c%0d", c), gnt, 64'(0));
    end
    dout_ready = 1'b1;
    tick;
    chk("bp release", 64'(dout_valid), 64'(0));

    // Async reset in HOLD discards the word and restarts the scan at 0.
    req = bit_of(50);
    dout_ready = 1'b0;
    tick;
    tick;
    chk("mid valid", 64'(dout_valid), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("mid rst valid", 64'(dout_valid), 64'(0));
    chk("mid rst gnt", gnt, 64'(0));
    chk("mid rst sel", 64'(sel), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    xact(bit_of(20) | bit_of(50), 6'd20, "after_rst");

`ifdef SCHED_LOCK_EN
    reset_dut;
    lock = 1'b1;
    xact(bit_of(7) | bit_of(8), 6'd7, "lock1");
    xact(bit_of(7) | bit_of(8), 6'd7, "lock2");
    lock = 1'b0;
    xact(bit_of(7) | bit_of(8), 6'd7, "lock3");
    xact(bit_of(7) | bit_of(8), 6'd8, "unlock");
`endif

    req = '0;
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
